// File: rtl/zrb_frame_pkg.sv
// Shared constants, state encoding and checksum helper for the ZRB command-frame parser.
package zrb_frame_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_CHK_ERR = 8'hE1;
  localparam logic [7:0] STATUS_CMD_ERR = 8'hE2;

  localparam int FRAME_LEN = 5;
  localparam int RESP_LEN  = 4;

  typedef enum logic [3:0] {
    ST_HUNT,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_CHK,
    ST_WR,
    ST_RD,
    ST_RDW,
    ST_RESP
  } parser_state_t;

  function automatic logic [7:0] frameChecksum(input logic [7:0] cmd,
                                               input logic [7:0] addr,
                                               input logic [7:0] data);
    return cmd ^ addr ^ data;
  endfunction

endpackage

// File: rtl/zrb_resp_sender.sv
// Serialises the 4-byte response frame (SOF, STATUS, RDATA, RCHK) into the TX FIFO,
// stalling while the FIFO is full.
module zrb_resp_sender
  import zrb_frame_pkg::*;
#(
  parameter logic [7:0] SOF = SOF_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] status_i,
  input  logic [7:0] rdata_i,
  input  logic       tx_full_i,
  output logic       tx_wr_o,
  output logic [7:0] tx_data_o,
  output logic       done_o
);

  localparam logic [1:0] LastIdx = 2'(RESP_LEN - 1);

  logic       active_q, active_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] status_q, status_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] curByte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      idx_q    <= 2'd0;
      status_q <= 8'h00;
      rdata_q  <= 8'h00;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    active_d  = active_q;
    idx_d     = idx_q;
    status_d  = status_q;
    rdata_d   = rdata_q;
    tx_wr_o   = 1'b0;
    tx_data_o = 8'h00;
    done_o    = 1'b0;

    case (idx_q)
      2'd0:    curByte = SOF;
      2'd1:    curByte = status_q;
      2'd2:    curByte = rdata_q;
      default: curByte = status_q ^ rdata_q;
    endcase

    // STATUS/RDATA are captured on start so the parser is free to move on.
    if (start_i) begin
      active_d = 1'b1;
      idx_d    = 2'd0;
      status_d = status_i;
      rdata_d  = rdata_i;
    end else if (active_q && !tx_full_i) begin
      tx_wr_o   = 1'b1;
      tx_data_o = curByte;
      idx_d     = idx_q + 2'd1;
      if (idx_q == LastIdx) begin
        active_d = 1'b0;
        done_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zrb_frame_parser.sv
// Decodes SOF/CMD/ADDR/DATA/CHK frames from the RX FIFO, drives the local register bus
// and queues a 4-byte response into the TX FIFO.
module zrb_frame_parser
  import zrb_frame_pkg::*;
#(
  parameter int         ADDR_WIDTH = 4,
  parameter int         TIMEOUT    = 255,
  parameter logic [7:0] SOF        = SOF_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_empty,
  output logic                  rx_rd,
  input  logic                  tick,
  output logic                  reg_we,
  output logic                  reg_re,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  input  logic [7:0]            reg_rdata,
  input  logic                  tx_full,
  output logic                  tx_wr,
  output logic [7:0]            tx_data,
  output logic                  frame_err,
  output logic                  busy
);

  localparam logic [7:0] TmoLim = 8'(TIMEOUT);

  parser_state_t state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    tmo_q, tmo_d;

  logic          respStart;
  logic [7:0]    respStatus;
  logic [7:0]    respRdata;
  logic          respDone;
  logic          inFrame;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_HUNT;
      cmd_q   <= 8'h00;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      tmo_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tmo_d      = 8'h00;
    rx_rd      = 1'b0;
    reg_we     = 1'b0;
    reg_re     = 1'b0;
    frame_err  = 1'b0;
    respStart  = 1'b0;
    respStatus = STATUS_OK;
    respRdata  = 8'h00;

    inFrame = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
              (state_q == ST_DATA) || (state_q == ST_CHK);

    // The pop strobe is suppressed during reset so nothing is lost from the RX FIFO.
    if ((inFrame || state_q == ST_HUNT) && !rx_empty && !reset) begin
      rx_rd = 1'b1;
    end

    case (state_q)
      ST_HUNT: if (rx_rd && rx_data == SOF) state_d = ST_CMD;
      ST_CMD: begin
        if (rx_rd) begin
          cmd_d   = rx_data;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rx_rd) begin
          addr_d  = rx_data;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_rd) begin
          data_d  = rx_data;
          state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (rx_rd) begin
          if (frameChecksum(cmd_q, addr_q, data_q) != rx_data) begin
            frame_err  = 1'b1;
            respStart  = 1'b1;
            respStatus = STATUS_CHK_ERR;
            state_d    = ST_RESP;
          end else if (cmd_q == CMD_WRITE) begin
            state_d = ST_WR;
          end else if (cmd_q == CMD_READ) begin
            state_d = ST_RD;
          end else begin
            frame_err  = 1'b1;
            respStart  = 1'b1;
            respStatus = STATUS_CMD_ERR;
            state_d    = ST_RESP;
          end
        end
      end
      ST_WR: begin
        reg_we    = 1'b1;
        respStart = 1'b1;
        respRdata = data_q;
        state_d   = ST_RESP;
      end
      ST_RD: begin
        reg_re  = 1'b1;
        state_d = ST_RDW;
      end
      ST_RDW: begin
        respStart = 1'b1;
        respRdata = reg_rdata;
        state_d   = ST_RESP;
      end
      ST_RESP: if (respDone) state_d = ST_HUNT;
      default: state_d = ST_HUNT;
    endcase

    // An accepted byte always wins over a same-cycle tick.
    if (inFrame && !rx_rd) begin
      tmo_d = tmo_q;
      if (tick) begin
        if (tmo_q + 8'd1 == TmoLim) begin
          tmo_d     = 8'h00;
          frame_err = 1'b1;
          state_d   = ST_HUNT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
    end
  end

  assign reg_addr  = addr_q[ADDR_WIDTH-1:0];
  assign reg_wdata = data_q;
  assign busy      = (state_q != ST_HUNT);

  zrb_resp_sender #(
    .SOF(SOF)
  ) u_resp_sender (
    .clk      (clk),
    .reset    (reset),
    .start_i  (respStart),
    .status_i (respStatus),
    .rdata_i  (respRdata),
    .tx_full_i(tx_full),
    .tx_wr_o  (tx_wr),
    .tx_data_o(tx_data),
    .done_o   (respDone)
  );

endmodule

// File: tb/tb_zrb_frame_parser.sv
// Directed bench for zrb_frame_parser: emulates the RX FIFO and register bus, predicts
// responses from the frame rules and checks every TX push and register strobe.
module tb_zrb_frame_parser;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data = 8'h00;
  logic       rx_empty = 1'b1;
  logic       rx_rd;
  logic       tick;
  logic       reg_we;
  logic       reg_re;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       tx_full;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       frame_err;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int errSeen = 0;
  int expErr = 0;

  logic [7:0]  rxq[$];
  logic [7:0]  expTx[$];
  logic [11:0] expWe[$];
  logic [3:0]  expRe[$];
  logic [7:0]  rdMem[16];

  zrb_frame_parser #(
    .ADDR_WIDTH(4),
    .TIMEOUT   (4),
    .SOF       (8'hA5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_empty (rx_empty),
    .rx_rd    (rx_rd),
    .tick     (tick),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .tx_full  (tx_full),
    .tx_wr    (tx_wr),
    .tx_data  (tx_data),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // RX FIFO with one cycle of push-to-visible latency; pops on the DUT strobe.
  always @(posedge clk) begin
    if (rx_rd && rxq.size() > 0) void'(rxq.pop_front());
    rx_empty <= (rxq.size() == 0);
    rx_data  <= (rxq.size() > 0) ? rxq[0] : 8'h00;
  end

  always @(posedge clk) begin
    if (reg_re) reg_rdata <= rdMem[reg_addr];
  end

  // Compare process: every TX push and register strobe must match the model queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_wr) begin
        checkOutput("tx_wr_while_full", {31'd0, tx_full}, 32'd0);
        if (expTx.size() == 0) checkOutput("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
        else checkOutput("tx_data", {24'd0, tx_data}, {24'd0, expTx.pop_front()});
      end
      if (reg_we) begin
        if (expWe.size() == 0) checkOutput("reg_we_unexpected", {20'd0, reg_addr, reg_wdata}, 32'hFFFF_FFFF);
        else checkOutput("reg_we_addr_wdata", {20'd0, reg_addr, reg_wdata}, {20'd0, expWe.pop_front()});
      end
      if (reg_re) begin
        if (expRe.size() == 0) checkOutput("reg_re_unexpected", {28'd0, reg_addr}, 32'hFFFF_FFFF);
        else checkOutput("reg_re_addr", {28'd0, reg_addr}, {28'd0, expRe.pop_front()});
      end
      if (rx_rd) checkOutput("rx_rd_when_empty", {31'd0, rx_empty}, 32'd0);
      if (frame_err) errSeen++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: the response each frame must produce, from the frame rules alone.
  task automatic modelFrame(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] k);
    logic [7:0] st;
    logic [7:0] rd;
    if ((c ^ a ^ d) != k) begin
      st = 8'hE1; rd = 8'h00; expErr++;
    end else if (c == 8'h01) begin
      st = 8'h00; rd = d; expWe.push_back({a[3:0], d});
    end else if (c == 8'h02) begin
      st = 8'h00; rd = rdMem[a[3:0]]; expRe.push_back(a[3:0]);
    end else begin
      st = 8'hE2; rd = 8'h00; expErr++;
    end
    expTx.push_back(8'hA5);
    expTx.push_back(st);
    expTx.push_back(rd);
    expTx.push_back(st ^ rd);
  endtask

  task automatic applyStimulus(input logic [7:0] c, input logic [7:0] a,
                               input logic [7:0] d, input logic [7:0] k);
    modelFrame(c, a, d, k);
    rxq.push_back(8'hA5);
    rxq.push_back(c);
    rxq.push_back(a);
    rxq.push_back(d);
    rxq.push_back(k);
  endtask

  task automatic waitIdle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (rxq.size() == 0 && rx_empty && !busy && expTx.size() == 0) done = 1'b1;
    end
    checkOutput({name, "_completes"}, {31'd0, done}, 32'd1);
    checkOutput({name, "_frame_err_count"}, errSeen, expErr);
    checkOutput({name, "_strobes_left"}, expWe.size() + expRe.size(), 32'd0);
  endtask

  task automatic waitRxDrained(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      step();
      if (rxq.size() == 0 && rx_empty) done = 1'b1;
    end
    checkOutput({name, "_rx_drained"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    tx_full = 1'b0;
    for (int i = 0; i < 16; i++) rdMem[i] = 8'(i * 3);
    rdMem[7] = 8'h3C;

    repeat (3) step();
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_strobes", {28'd0, tx_wr, reg_we, reg_re, frame_err}, 32'd0);
    checkOutput("reset_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("reset_reg_bus", {20'd0, reg_addr, reg_wdata}, 32'd0);
    reset = 1'b0;
    step();

    // Write: A5 01 03 5C 5E
    applyStimulus(8'h01, 8'h03, 8'h5C, 8'h5E);
    checkOutput("model_wr_status", {24'd0, expTx[1]}, 32'h00);
    checkOutput("model_wr_rchk", {24'd0, expTx[3]}, 32'h5C);
    waitIdle("write");
    checkOutput("write_reg_hold", {20'd0, reg_addr, reg_wdata}, 32'h35C);

    // Read: A5 02 07 00 05 with register 7 holding 3C
    applyStimulus(8'h02, 8'h07, 8'h00, 8'h05);
    checkOutput("model_rd_rdata", {24'd0, expTx[2]}, 32'h3C);
    waitIdle("read");

    // Bad checksum: A5 01 03 5C 00
    applyStimulus(8'h01, 8'h03, 8'h5C, 8'h00);
    checkOutput("model_chk_rchk", {24'd0, expTx[3]}, 32'hE1);
    waitIdle("bad_chk");
    checkOutput("bad_chk_one_err", errSeen, 32'd1);

    // Unknown command: A5 09 00 00 09
    applyStimulus(8'h09, 8'h00, 8'h00, 8'h09);
    checkOutput("model_cmd_status", {24'd0, expTx[1]}, 32'hE2);
    waitIdle("bad_cmd");
    checkOutput("bad_cmd_two_errs", errSeen, 32'd2);

    // Noise then a truncated frame abandoned by the inter-byte timeout.
    rxq.push_back(8'h11);
    rxq.push_back(8'h22);
    rxq.push_back(8'hA5);
    rxq.push_back(8'h01);
    repeat (8) step();
    checkOutput("noise_popped", rxq.size(), 32'd0);
    checkOutput("noise_in_frame_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) expErr++;
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
      if (i == 2) checkOutput("timeout_not_early", {31'd0, busy}, 32'd1);
    end
    checkOutput("timeout_hunt", {31'd0, busy}, 32'd0);
    checkOutput("timeout_err_count", errSeen, expErr);
    checkOutput("timeout_no_tx", expTx.size(), 32'd0);

    applyStimulus(8'h01, 8'h0A, 8'h77, 8'h01 ^ 8'h0A ^ 8'h77);
    waitIdle("after_timeout");

    // Backpressure: response held off while the TX FIFO is full.
    tx_full = 1'b1;
    applyStimulus(8'h01, 8'h05, 8'hA0, 8'hA4);
    waitRxDrained("bp");
    for (int i = 0; i < 12; i++) begin
      step();
      checkOutput("bp_no_tx_wr", {31'd0, tx_wr}, 32'd0);
    end
    tx_full = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("bp_burst_tx_wr", {31'd0, tx_wr}, 32'd1);
      step();
    end
    checkOutput("bp_done_tx_wr", {31'd0, tx_wr}, 32'd0);
    checkOutput("bp_done_busy", {31'd0, busy}, 32'd0);
    checkOutput("bp_all_bytes", expTx.size(), 32'd0);

    // Reset in the middle of a response abandons the remaining bytes.
    tx_full = 1'b1;
    applyStimulus(8'h01, 8'h02, 8'h11, 8'h12);
    waitRxDrained("rst");
    repeat (4) step();
    tx_full = 1'b0;
    #1;
    checkOutput("rst_byte0_tx_wr", {31'd0, tx_wr}, 32'd1);
    step();
    checkOutput("rst_byte1_tx_wr", {31'd0, tx_wr}, 32'd1);
    step();
    reset = 1'b1;
    #1;
    checkOutput("rst_tx_wr_drops", {31'd0, tx_wr}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_partial_left", expTx.size(), 32'd2);
    expTx.delete();
    repeat (2) step();
    reset = 1'b0;
    repeat (6) step();
    checkOutput("rst_no_resume_tx", {31'd0, tx_wr}, 32'd0);

    applyStimulus(8'h02, 8'h07, 8'h00, 8'h05);
    waitIdle("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
